// File: rtl/heap_sort_result_checker.sv
// Sink-side checker for the heap sort stream: verifies sort order, element count and
// checksum of one run against the summary from the stimulus generator.
module heap_sort_result_checker #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SUM_W      = 40,
    parameter int unsigned DESCENDING = 0,
    parameter int unsigned STALL_EN   = 0
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              exp_valid,
    input  logic [CNT_W-1:0]  exp_count,
    input  logic [SUM_W-1:0]  exp_sum,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  elem_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] ErrNone  = 3'd0;
    localparam logic [2:0] ErrOrder = 3'd1;
    localparam logic [2:0] ErrCount = 3'd2;
    localparam logic [2:0] ErrSum   = 3'd3;

    state_e            state;
    logic [7:0]        lfsr;
    logic [DATA_W-1:0] prev;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  exp_sum_q;
    logic [CNT_W-1:0]  exp_cnt_q;

    logic              xfer;
    logic              lfsr_fb;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [SUM_W-1:0]  sum_nxt;
    logic              at_exp;
    logic              term;
    logic              order_bad;
    logic [2:0]        err_nxt;

    assign s_ready = (state == StRun) && ((STALL_EN == 0) || lfsr[0]);
    assign xfer    = s_valid && s_ready;
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_comb begin
        cnt_nxt = elem_count + CNT_W'(1);
        sum_nxt = sum + SUM_W'(s_data);
        at_exp  = (cnt_nxt == exp_cnt_q);
        term    = s_last || at_exp;
        if (DESCENDING != 0) begin
            order_bad = (s_data > prev);
        end else begin
            order_bad = (s_data < prev);
        end
        // The first element of a run has no predecessor to compare against.
        order_bad = order_bad && (elem_count != '0);

        err_nxt = err_code;
        if (err_code == ErrNone) begin
            if (order_bad) begin
                err_nxt = ErrOrder;
            end else if (term && (s_last != at_exp)) begin
                err_nxt = ErrCount;
            end else if (term && (sum_nxt != exp_sum_q)) begin
                err_nxt = ErrSum;
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state      <= StIdle;
            lfsr       <= 8'hA5;
            prev       <= '0;
            sum        <= '0;
            exp_sum_q  <= '0;
            exp_cnt_q  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_code   <= ErrNone;
            elem_count <= '0;
        end else begin
            if (state == StRun) begin
                lfsr <= {lfsr[6:0], lfsr_fb};
            end
            unique case (state)
                StIdle, StDone: begin
                    if (exp_valid) begin
                        // A zero count cannot terminate a run, so treat it as one element.
                        exp_cnt_q  <= (exp_count == '0) ? CNT_W'(1) : exp_count;
                        exp_sum_q  <= exp_sum;
                        elem_count <= '0;
                        sum        <= '0;
                        prev       <= '0;
                        err_code   <= ErrNone;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    if (xfer) begin
                        sum        <= sum_nxt;
                        elem_count <= cnt_nxt;
                        prev       <= s_data;
                        err_code   <= err_nxt;
                        if (term) begin
                            done  <= 1'b1;
                            pass  <= (err_nxt == ErrNone);
                            state <= StDone;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_sort_result_checker.sv
// Directed bench for heap_sort_result_checker: three instances (plain, stalled, descending)
// driven from one sequence; verdicts are queued at stimulus time and compared at done.
module tb_heap_sort_result_checker;

    logic        clk;
    logic        rstn;
    logic [2:0]  exp_valid_v;
    logic [7:0]  exp_count;
    logic [39:0] exp_sum;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;

    logic        s_ready_v [3];
    logic        done_v    [3];
    logic        pass_v    [3];
    logic [2:0]  err_v     [3];
    logic [7:0]  cnt_v     [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       pass;
        logic [2:0] err;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    heap_sort_result_checker u_plain (
        .system1000(clk), .system1000_rstn(rstn), .exp_valid(exp_valid_v[0]),
        .exp_count(exp_count), .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_code(err_v[0]), .elem_count(cnt_v[0])
    );

    heap_sort_result_checker #(.STALL_EN(1)) u_stall (
        .system1000(clk), .system1000_rstn(rstn), .exp_valid(exp_valid_v[1]),
        .exp_count(exp_count), .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_code(err_v[1]), .elem_count(cnt_v[1])
    );

    heap_sort_result_checker #(.DESCENDING(1)) u_desc (
        .system1000(clk), .system1000_rstn(rstn), .exp_valid(exp_valid_v[2]),
        .exp_count(exp_count), .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_code(err_v[2]), .elem_count(cnt_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int sel, input string tag);
        chk({tag, "_s_ready"}, s_ready_v[sel], 0);
        chk({tag, "_done"}, done_v[sel], 0);
        chk({tag, "_pass"}, pass_v[sel], 0);
        chk({tag, "_err"}, err_v[sel], 0);
        chk({tag, "_cnt"}, cnt_v[sel], 0);
    endtask

    // Called at #1 after a rising edge.
    task automatic start(input int sel, input logic [7:0] c, input logic [39:0] s);
        exp_count        = c;
        exp_sum          = s;
        exp_valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        exp_valid_v[sel] = 1'b0;
        chk("start_done", done_v[sel], 0);
        chk("start_cnt", cnt_v[sel], 0);
    endtask

    task automatic send(input int sel, input logic [31:0] d, input logic last,
                        input logic exp_done);
        logic rdy;
        int   waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge clk);
            rdy = s_ready_v[sel];
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 200);
        chk("xfer_timeout", rdy, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("done_latency", done_v[sel], exp_done);
    endtask

    task automatic run(input int sel, input string tag, input logic [7:0] c,
                       input logic [39:0] s, input logic [31:0] d [8], input int n,
                       input logic lastf, input logic epass, input logic [2:0] eerr,
                       input logic [7:0] ecnt);
        exp_t e;
        sb.push_back('{tag: tag, pass: epass, err: eerr, cnt: ecnt});
        start(sel, c, s);
        for (int i = 0; i < n; i++) begin
            send(sel, d[i], lastf && (i == n - 1), i == n - 1);
        end
        e = sb.pop_front();
        chk({e.tag, "_pass"}, pass_v[sel], e.pass);
        chk({e.tag, "_err"}, err_v[sel], e.err);
        chk({e.tag, "_cnt"}, cnt_v[sel], e.cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        exp_valid_v = '0;
        exp_count   = '0;
        exp_sum     = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        #2;
        check_zero(0, "reset");
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Data offered while idle must not be consumed.
        s_valid = 1'b1;
        s_data  = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("idle_ready", s_ready_v[0], 0);
        chk("idle_cnt", cnt_v[0], 0);

        run(0, "asc5", 8'd5, 40'd15, '{1, 2, 3, 4, 5, 0, 0, 0}, 5, 1'b1, 1'b1, 3'd0, 8'd5);
        run(0, "order", 8'd5, 40'd15, '{1, 3, 2, 4, 5, 0, 0, 0}, 5, 1'b1, 1'b0, 3'd1, 8'd5);
        run(0, "early_last", 8'd4, 40'd15, '{7, 8, 0, 0, 0, 0, 0, 0}, 2, 1'b1,
            1'b0, 3'd2, 8'd2);
        run(0, "missing_last", 8'd3, 40'd6, '{1, 2, 3, 0, 0, 0, 0, 0}, 3, 1'b0,
            1'b0, 3'd2, 8'd3);
        run(0, "sum_wrap", 8'd3, 40'h2FFFFFFFD,
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0}, 3, 1'b1,
            1'b1, 3'd0, 8'd3);
        run(0, "sum_bad", 8'd3, 40'd0,
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0}, 3, 1'b1,
            1'b0, 3'd3, 8'd3);
        run(0, "zero_count", 8'd0, 40'd6, '{6, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1,
            1'b1, 3'd0, 8'd1);

        // Verdict holds in DONE and further data is refused.
        s_valid = 1'b1;
        s_data  = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("done_hold_ready", s_ready_v[0], 0);
        chk("done_hold_cnt", cnt_v[0], 1);
        chk("done_hold_done", done_v[0], 1);
        chk("done_hold_pass", pass_v[0], 1);

        run(1, "stall_dup", 8'd3, 40'd17, '{4, 4, 9, 0, 0, 0, 0, 0}, 3, 1'b1,
            1'b1, 3'd0, 8'd3);
        run(2, "desc_dup", 8'd3, 40'd17, '{9, 4, 4, 0, 0, 0, 0, 0}, 3, 1'b1,
            1'b1, 3'd0, 8'd3);
        run(2, "desc_order", 8'd3, 40'd17, '{4, 9, 4, 0, 0, 0, 0, 0}, 3, 1'b1,
            1'b0, 3'd1, 8'd3);

        // Reset lands between edges, after two transfers of a five-element run.
        start(0, 8'd5, 40'd15);
        send(0, 32'd1, 1'b0, 1'b0);
        send(0, 32'd2, 1'b0, 1'b0);
        chk("pre_reset_cnt", cnt_v[0], 2);
        #2;
        rstn = 1'b0;
        #1;
        check_zero(0, "mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_zero(0, "post_reset_idle");
        run(0, "after_reset", 8'd5, 40'd15, '{1, 2, 3, 4, 5, 0, 0, 0}, 5, 1'b1,
            1'b1, 3'd0, 8'd5);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/heap_sort_result_checker.md
Name: heap_sort_result_checker

Overview:
- Sink end of the HeapSort bench stream: consumes the sorted output of the heap sort core and checks it against the summary published by the stimulus generator.
- The summary is the element count and a modular checksum of all inputs.
- Checks three things: sort order, element count and checksum.
- Reports a sticky pass/fail verdict and first-error code for the top-level bench.

Parameters:
- DATA_W, 32, width of one sorted element.
- CNT_W, 8, width of element counters (max run length 2^CNT_W-1).
- SUM_W, 40, width of the modular checksum.
- DESCENDING, 0, 0 = require non-decreasing order; 1 = require non-increasing order.
- STALL_EN, 0, 1 = throttle s_ready with an internal 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).

Ports:
- system1000  in  1  clock, all state on rising edge.
- system1000_rstn  in  1  asynchronous reset, active low.
- exp_valid  in  1  single-cycle strobe carrying the expected run summary.
- exp_count  in  CNT_W  expected number of elements (0 is illegal; treated as 1).
- exp_sum  in  SUM_W  expected sum of all elements mod 2^SUM_W.
- s_valid  in  1  sorted element valid.
- s_data  in  DATA_W  sorted element.
- s_last  in  1  marks final element of the run, qualified by s_valid.
- s_ready  out  1  checker accepts element this cycle.
- done  out  1  run finished, verdict valid.
- pass  out  1  run finished with no error.
- err_code  out  3  first error: 0 none, 1 order, 2 count, 3 checksum.
- elem_count  out  CNT_W  elements accepted in the current or last run.

Behaviour:
- Reset (async, rstn low): state IDLE. s_ready=0, done=0, pass=0, err_code=0, elem_count=0, LFSR=8'hA5. Internal prev/sum/expected registers = 0.
- Transfer: s_valid & s_ready on a rising edge. s_data/s_last are ignored otherwise.
- IDLE:
  - s_ready=0.
  - On exp_valid: latch exp_count/exp_sum; clear elem_count, sum, err_code, done, pass; go to RUN next cycle.
- RUN:
  - s_ready=1, or LFSR[0] when STALL_EN=1. The LFSR advances every cycle in RUN.
  - On each transfer: sum += s_data (zero-extended, wrap mod 2^SUM_W); elem_count++; prev=s_data.
  - Order check applies when elem_count>0 before the increment. It flags s_data<prev (ascending) or s_data>prev (descending). Equal values are legal.
  - Order error is recorded only if err_code==0. The run continues after an order error.
- Run termination, on the transfer where s_last=1 or the new count == exp_count:
  - Count error (code 2) if s_last differs from (new count == exp_count). This covers both early last and a missing last at exp_count.
  - Checksum error (code 3) if the final sum (including this element) != exp_sum.
  - Only the first error is kept. Priority on the final transfer, when err_code is still 0: order > count > sum.
  - Go to DONE next cycle.
- DONE:
  - s_ready=0; done=1; pass=(err_code==0). Outputs hold.
  - exp_valid returns to RUN with all verdict state cleared. done and pass drop the same cycle the new run state loads.
- exp_valid while in RUN is ignored.
- s_valid while in IDLE/DONE is not accepted (s_ready=0) and is not an error.
- Latency: done rises exactly one cycle after the final transfer. Sum/count comparison is registered within that cycle; no extra pipeline.
- Counter wrap: elem_count never exceeds exp_count, because termination is forced at equality.
- Reset mid-run aborts immediately to reset values; no partial verdict is retained.

Test Plan:
- Ascending 5-element run: exp_count=5, exp_sum=15, data 1,2,3,4,5 with last on 5 -> done=1 one cycle after the 5th transfer, pass=1, err_code=0, elem_count=5.
- Order violation: data 1,3,2,4,5, exp_sum=15 -> order error recorded at the 3rd transfer, run continues; done after the 5th transfer, pass=0, err_code=1.
- Early last: exp_count=4, data 7,8 with last on 8 -> done, err_code=2, elem_count=2. Missing last: exp_count=3, data 1,2,3 without last -> done after the 3rd transfer, err_code=2.
- Checksum wrap: SUM_W=40, three elements 32'hFFFFFFFF, exp_sum=40'h2FFFFFFFD -> pass=1. Same run with exp_sum=0 -> err_code=3.
- Stall and duplicates: STALL_EN=1, s_valid held high, data 4,4,9 -> only cycles with s_ready=1 transfer; pass=1, elem_count=3. DESCENDING=1 with 9,4,4 -> pass=1.
- Reset mid-run after 2 transfers -> all outputs 0 asynchronously, state IDLE. A new exp_valid then starts a clean run.
